// File: rtl/api_txarb_if.sv
// api_txarb_if: requester word handshakes plus the TX FIFO push/status signals seen by api_txarb.
// The master modport is the arbiter side; slave is the producers/FIFO side.
interface api_txarb_if #(
    parameter int unsigned REQ_NUM = 4
);
    logic [REQ_NUM-1:0]    req_valid;
    logic [32*REQ_NUM-1:0] req_data;
    logic [REQ_NUM-1:0]    req_ready;
    logic [9:0]            txcnt;
    logic                  txfull;
    logic                  txfifo_push;
    logic [31:0]           txfifo_din;

    modport master (
        input  req_valid, req_data, txcnt, txfull,
        output req_ready, txfifo_push, txfifo_din
    );

    modport slave (
        output req_valid, req_data, txcnt, txfull,
        input  req_ready, txfifo_push, txfifo_din
    );
endinterface

// File: rtl/api_txarb.sv
// api_txarb: round-robin whole-packet arbiter in front of the API SPI TX FIFO push port.
// Optional stall timeout with zero padding is enabled by defining API_TXARB_TIMEOUT_EN.
module api_txarb #(
    parameter int unsigned REQ_NUM       = 4,
    parameter int unsigned TX_FIFO_DEPTH = 512,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    api_txarb_if.master bus,
    input  logic [7:0]  reg_word_num,
    output logic        busy,
    output logic [2:0]  grant_id,
    output logic        pkt_done,
    output logic        pkt_err
);
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  last_q, last_d, gid_d, winner;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic        gap_q, gap_d, busy_d, push_d, done_d;
    logic        found, ready_en, step, space_ok;
    logic [31:0] din_d, step_data;
    logic [3:0]  sum;
    logic [7:0]  vld8;
    logic [10:0] free_words;
    logic [31:0] data_arr [8];

`ifdef API_TXARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        pad_q, pad_d, err_d;
`endif

    // Requesters are padded out to 8 lanes so grant_id can index them directly.
    assign vld8 = 8'(bus.req_valid);

    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < REQ_NUM) begin : g_used
            assign data_arr[g]      = bus.req_data[32*g +: 32];
            assign bus.req_ready[g] = ready_en && (grant_id == 3'(g));
        end else begin : g_pad
            assign data_arr[g] = '0;
        end
    end

    assign free_words = 11'(TX_FIFO_DEPTH) - {1'b0, bus.txcnt};
    assign space_ok   = ({1'b0, bus.txcnt} <= 11'(TX_FIFO_DEPTH)) &&
                        (free_words >= {3'b000, reg_word_num});

    // Rotating priority search starting just after the last granted requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        for (int unsigned k = 1; k <= REQ_NUM; k++) begin
            sum = {1'b0, last_q} + 4'(k);
            if (sum >= 4'(REQ_NUM)) sum = sum - 4'(REQ_NUM);
            if (!found && vld8[sum[2:0]]) begin
                winner = sum[2:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = grant_id;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        gap_d     = gap_q;
        busy_d    = busy;
        push_d    = 1'b0;
        din_d     = bus.txfifo_din;
        done_d    = 1'b0;
        ready_en  = 1'b0;
        step      = 1'b0;
        step_data = '0;
`ifdef API_TXARB_TIMEOUT_EN
        stall_d   = stall_q;
        pad_d     = pad_q;
        err_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found && (reg_word_num != '0) && space_ok) begin
                    gid_d   = winner;
                    wlen_d  = reg_word_num;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
`ifdef API_TXARB_TIMEOUT_EN
                if (pad_q) begin
                    step = !bus.txfull;
                end else begin
                    ready_en  = !bus.txfull;
                    step      = ready_en && vld8[grant_id];
                    step_data = data_arr[grant_id];
                    if (step) begin
                        stall_d = '0;
                    end else if (!vld8[grant_id]) begin
                        stall_d = stall_q + 16'd1;
                        if (stall_d >= 16'(TIMEOUT)) pad_d = 1'b1;
                    end
                end
`else
                ready_en  = !bus.txfull;
                step      = ready_en && vld8[grant_id];
                step_data = data_arr[grant_id];
`endif
                if (step) begin
                    push_d = 1'b1;
                    din_d  = step_data;
                    if (wcnt_q == wlen_q - 8'd1) begin
                        done_d  = 1'b1;
                        last_d  = grant_id;
                        wcnt_d  = '0;
                        gap_d   = 1'b0;
                        state_d = GAP;
`ifdef API_TXARB_TIMEOUT_EN
                        err_d   = pad_q;
                        pad_d   = 1'b0;
                        stall_d = '0;
`endif
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            GAP: begin
                // Two idle cycles so txcnt catches up with the registered pushes.
                if (gap_q) begin
                    gap_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            last_q          <= 3'(REQ_NUM - 1);
            grant_id        <= '0;
            wlen_q          <= '0;
            wcnt_q          <= '0;
            gap_q           <= 1'b0;
            busy            <= 1'b0;
            bus.txfifo_push <= 1'b0;
            bus.txfifo_din  <= '0;
            pkt_done        <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            grant_id        <= gid_d;
            wlen_q          <= wlen_d;
            wcnt_q          <= wcnt_d;
            gap_q           <= gap_d;
            busy            <= busy_d;
            bus.txfifo_push <= push_d;
            bus.txfifo_din  <= din_d;
            pkt_done        <= done_d;
        end
    end

`ifdef API_TXARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            pad_q   <= 1'b0;
            pkt_err <= 1'b0;
        end else begin
            stall_q <= stall_d;
            pad_q   <= pad_d;
            pkt_err <= err_d;
        end
    end
`else
    assign pkt_err = 1'b0;
`endif
endmodule
